// File: rtl/mskaes_prng_pkg.sv
// mskaes_prng_pkg: shared constants, types and helper functions for the
// mask-randomness PRNG that feeds the masked AES-128 core.
//   - LFSR_W / LANE_OUT_W : lane state width and bits produced per cycle
//   - GOLDEN              : per-lane seed diversification constant
//   - lfsr_step32         : 32 unrolled steps of x^127+x^126+1
//   - lane_seed           : seed-to-lane-state mapping with zero-state fix
//   - state_t             : controller states
package mskaes_prng_pkg;

  localparam int LFSR_W     = 127;
  localparam int LANE_OUT_W = 32;
  localparam int SEED_W     = 128;
  localparam int TAP_HI     = 126;
  localparam int TAP_LO     = 125;
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

  typedef struct packed {
    logic [LFSR_W-1:0]     state;
    logic [LANE_OUT_W-1:0] bits;
  } step_t;

  // Feedback bit j of the cycle becomes output bit j (j=0 first).
  function automatic step_t lfsr_step32(input logic [LFSR_W-1:0] s);
    step_t r;
    logic  fb;
    r.state = s;
    r.bits  = '0;
    for (int j = 0; j < LANE_OUT_W; j++) begin
      fb        = r.state[TAP_HI] ^ r.state[TAP_LO];
      r.bits[j] = fb;
      r.state   = {r.state[LFSR_W-2:0], fb};
    end
    return r;
  endfunction

  // Seed bit 127 folds into bit 0; each lane is offset by its own constant
  // so lanes never share a state. The all-zero state would lock the LFSR.
  function automatic logic [LFSR_W-1:0] lane_seed(input logic [SEED_W-1:0] seed,
                                                  input int unsigned      idx);
    logic [31:0]       c;
    logic [LFSR_W-1:0] s;
    c = GOLDEN * (idx + 32'd1);
    s = seed[LFSR_W-1:0] ^ {126'b0, seed[SEED_W-1]} ^ {95'b0, c};
    if (s == '0) s[0] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/mskaes_prng_lane.sv
// mskaes_prng_lane: one 127-bit Fibonacci LFSR lane, 32 steps per cycle.
// Ports:
//   clk, nrst  : clock, synchronous active-low reset (state and output to 0)
//   load       : load load_val into the lane (takes precedence over step)
//   step       : advance 32 steps and register the 32 feedback bits
//   load_val   : lane seed state
//   out        : registered 32-bit output of the most recent step
module mskaes_prng_lane
  import mskaes_prng_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  load,
  input  logic                  step,
  input  logic [LFSR_W-1:0]     load_val,
  output logic [LANE_OUT_W-1:0] out
);

  logic [LFSR_W-1:0]     state_q;
  logic [LANE_OUT_W-1:0] out_q;
  step_t                 nxt;

  always_comb nxt = lfsr_step32(state_q);

  // A load leaves the output register holding its previous word.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= '0;
      out_q   <= '0;
    end else if (load) begin
      state_q <= load_val;
    end else if (step) begin
      state_q <= nxt.state;
      out_q   <= nxt.bits;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/mskaes_prng.sv
// mskaes_prng: seedable randomness source for the masked AES fresh-mask
// buses. After a reseed it runs WARMUP warm-up cycles, then delivers RND_W
// fresh bits every cycle with out_valid high.
// Ports:
//   clk          : clock
//   nrst         : synchronous active-low reset
//   start_reseed : single-cycle reseed request (seed sampled in that cycle)
//   seed         : 128-bit seed
//   out_valid    : rnd_out holds post-warm-up randomness
//   rnd_out      : RND_W registered random bits
// Configuration macro MSKAES_PRNG_OUT_GATE_EN: when defined, rnd_out is
// forced to 0 whenever out_valid is 0.
module mskaes_prng
  import mskaes_prng_pkg::*;
#(
  parameter int RND_W  = 680,
  parameter int WARMUP = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_reseed,
  input  logic [127:0]     seed,
  output logic             out_valid,
  output logic [RND_W-1:0] rnd_out
);

  localparam int LANES = (RND_W + LANE_OUT_W - 1) / LANE_OUT_W;
  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP - 1);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        vld_q, vld_d;
  logic                        lane_step;
  logic [LANES*LANE_OUT_W-1:0] raw;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  // A reseed wins over stepping in every state; the lanes load instead.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vld_d     = vld_q;
    lane_step = 1'b0;
    if (start_reseed) begin
      state_d = WARM;
      cnt_d   = '0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        WARM: begin
          lane_step = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            vld_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN:     lane_step = 1'b1;
        default: state_d   = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mskaes_prng_lane u_lane (
      .clk      (clk),
      .nrst     (nrst),
      .load     (start_reseed),
      .step     (lane_step),
      .load_val (lane_seed(seed, i)),
      .out      (raw[i*LANE_OUT_W +: LANE_OUT_W])
    );
  end

  // Lane bits above RND_W are produced but never leave the block.
  if (LANES * LANE_OUT_W > RND_W) begin : g_trunc
    logic unused_raw;
    assign unused_raw = ^raw[LANES*LANE_OUT_W-1:RND_W];
  end

  assign out_valid = vld_q;

`ifdef MSKAES_PRNG_OUT_GATE_EN
  assign rnd_out = vld_q ? raw[RND_W-1:0] : '0;
`else
  assign rnd_out = raw[RND_W-1:0];
`endif

endmodule

// File: tb/tb_mskaes_prng.sv
// tb_mskaes_prng: scoreboard bench for mskaes_prng (RND_W=680, WARMUP=4).
// Stimulus advances a behavioural model one edge at a time and queues the
// expected out_valid/rnd_out; a monitor pops and compares on every falling
// edge.
module tb_mskaes_prng;

  localparam int RND_W  = 680;
  localparam int WARMUP = 4;
  localparam int LANES  = 22;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             start_reseed = 1'b0;
  logic [127:0]     seed = '0;
  logic             out_valid;
  logic [RND_W-1:0] rnd_out;

  always #5 clk = ~clk;

  mskaes_prng #(.RND_W(RND_W), .WARMUP(WARMUP)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start_reseed (start_reseed),
    .seed         (seed),
    .out_valid    (out_valid),
    .rnd_out      (rnd_out)
  );

  typedef struct packed {
    logic             vld;
    logic             chk;
    logic [RND_W-1:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_mon = 0;

  // Behavioural model
  logic [126:0] m_lane [LANES];
  logic [31:0]  m_word [LANES];
  int           m_st;
  int           m_cnt;
  logic         m_vld;

  localparam logic [127:0] SEED_A = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] SEED_B = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SEED_Z = 128'h9E3779B9;

  function automatic logic [126:0] m_seed(input logic [127:0] sd, input int i);
    logic [31:0]  c;
    logic [126:0] v;
    c = 32'(64'h9E3779B9 * 64'(i + 1));
    v = sd[126:0];
    v[0]    = v[0] ^ sd[127];
    v[31:0] = v[31:0] ^ c;
    if (v == 127'd0) v = 127'd1;
    return v;
  endfunction

  task automatic m_adv(input int i);
    logic b;
    for (int j = 0; j < 32; j++) begin
      b = m_lane[i][126] ^ m_lane[i][125];
      m_word[i][j] = b;
      m_lane[i] = (m_lane[i] << 1) | 127'(b);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance model, queue expectation.
  task automatic tick(input logic r, input logic rs, input logic [127:0] sd,
                      input logic use_hand, input logic [31:0] hand0);
    exp_t                e;
    logic                ld;
    logic [LANES*32-1:0] full;
    nrst = r;
    start_reseed = rs;
    seed = sd;
    @(posedge clk);
    ld = 1'b0;
    if (!r) begin
      for (int i = 0; i < LANES; i++) begin
        m_lane[i] = '0;
        m_word[i] = '0;
      end
      m_st = 0; m_cnt = 0; m_vld = 1'b0;
    end else if (rs) begin
      for (int i = 0; i < LANES; i++) m_lane[i] = m_seed(sd, i);
      m_st = 1; m_cnt = 0; m_vld = 1'b0; ld = 1'b1;
    end else if (m_st != 0) begin
      for (int i = 0; i < LANES; i++) m_adv(i);
      if (m_st == 1) begin
        if (m_cnt == WARMUP - 1) begin
          m_st = 2; m_vld = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
    for (int i = 0; i < LANES; i++) full[i*32 +: 32] = m_word[i];
    e.vld  = m_vld;
    e.data = full[RND_W-1:0];
`ifdef MSKAES_PRNG_OUT_GATE_EN
    e.chk = 1'b1;
    if (!m_vld) e.data = '0;
`else
    e.chk = !ld;
`endif
    if (use_hand) e.data[31:0] = hand0;
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 128'd0, 1'b0, 32'd0);
  endtask

  task automatic reseed(input logic [127:0] sd);
    tick(1'b1, 1'b1, sd, 1'b0, 32'd0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_mon++;
        n_cmp++;
        if (out_valid !== e.vld || (e.chk && rnd_out !== e.data)) begin
          n_bad++;
          $display("FAIL cyc%0d out_valid got %b want %b rnd_out got %h want %h",
                   n_mon, out_valid, e.vld, rnd_out, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < LANES; i++) begin
      m_lane[i] = '0;
      m_word[i] = '0;
    end
    m_st = 0; m_cnt = 0; m_vld = 1'b0;

    // Reset for 3 cycles, then idle with no reseed: everything stays 0
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 128'd0, 1'b0, 32'd0);
    idle(6);

    // Latency and 64 run words under SEED_A
    reseed(SEED_A);
    idle(WARMUP + 64);

    // Restart, 10 run cycles, then reseed mid-RUN with SEED_B
    reseed(SEED_A);
    idle(WARMUP + 10);
    reseed(SEED_B);
    idle(WARMUP + 20);

    // Zero-lane fix: lane 0 loads 1, first valid lane-0 word is 0x60000000
    reseed(SEED_Z);
    idle(WARMUP - 1);
    tick(1'b1, 1'b0, 128'd0, 1'b1, 32'h6000_0000);
    idle(12);

    // Reset two cycles after a reseed, then reseed as from power-up
    reseed(SEED_B);
    idle(1);
    tick(1'b0, 1'b0, 128'd0, 1'b0, 32'd0);
    idle(4);
    reseed(SEED_A);
    idle(WARMUP + 8);

    // Back-to-back reseeds: only the last seed counts
    reseed(SEED_B);
    reseed(SEED_Z);
    reseed(SEED_A);
    idle(WARMUP + 8);

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: queue entries left got %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
